// File: rtl/delay_line_param.sv
// delay_line_param: DEPTH-stage valid/data delay line with selectable tap.
// Optional fill counter under `DELAY_LINE_FILL_CNT_EN.
//
// Ports:
//   clk       in   clock, all state on rising edge
//   rst       in   synchronous active-high reset
//   en        in   advance the line by one stage
//   flush     in   synchronous clear of all stages
//   dly_sel   in   selected delay minus one, clamped to DEPTH-1
//   in_valid  in   data_in qualifier
//   data_in   in   sample
//   out_valid out  valid bit of the selected stage
//   data_out  out  data of the selected stage, RST_VAL when invalid
//   fill_cnt  out  number of valid stages (only with DELAY_LINE_FILL_CNT_EN)
module delay_line_param #(
    parameter int unsigned      WIDTH   = 16,
    parameter int unsigned      DEPTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic [$clog2(DEPTH)-1:0]   dly_sel,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           data_out
`ifdef DELAY_LINE_FILL_CNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] fill_cnt
`endif
);

    localparam int unsigned SW = $clog2(DEPTH);

    localparam logic [SW:0] K_MAX_X = (SW+1)'(DEPTH - 1);

    // Power-up values match the reset values.
    logic [DEPTH-1:0]            vld_q = '0;
    logic [DEPTH-1:0][WIDTH-1:0] data_q = {DEPTH{RST_VAL}};

    logic [DEPTH-1:0]            vld_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;

    logic [SW:0]                 sel_x;
    logic [SW-1:0]               k;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (rst || flush) begin
            vld_d  = '0;
            data_d = {DEPTH{RST_VAL}};
        end else if (en) begin
            vld_d  = {vld_q[DEPTH-2:0], in_valid};
            data_d = {data_q[DEPTH-2:0], data_in};
        end
    end

    always_ff @(posedge clk) begin
        vld_q  <= vld_d;
        data_q <= data_d;
    end

    // Compare one bit wider so that non-power-of-two depths clamp
    // correctly without a constant-range comparison.
    always_comb begin
        sel_x = {1'b0, dly_sel};
        if (sel_x > K_MAX_X) begin
            k = K_MAX_X[SW-1:0];
        end else begin
            k = dly_sel;
        end
    end

    assign out_valid = vld_q[k];
    assign data_out  = vld_q[k] ? data_q[k] : RST_VAL;

`ifdef DELAY_LINE_FILL_CNT_EN
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [CW-1:0] cnt_q = '0;
    logic [CW-1:0] cnt_d;

    // A sample entering and one leaving in the same edge cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (rst || flush) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(in_valid) - CW'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign fill_cnt = cnt_q;
`endif

endmodule
